// File: rtl/hyperbus_resp_model_if.sv
// HyperBus pin bundle after DDR deserialization: one 16-bit word per CK period.
// The master modport is the controller side, and the slave modport is the responder side.
interface hyperbus_resp_model_if;
   logic        hyper_cs_ni;
   logic [15:0] hyper_dq_i;
   logic [1:0]  hyper_rwds_i;
   logic [15:0] hyper_dq_o;
   logic        hyper_dq_oe_o;
   logic [1:0]  hyper_rwds_o;
   logic        hyper_rwds_oe_o;

   modport master (
      output hyper_cs_ni, hyper_dq_i, hyper_rwds_i,
      input  hyper_dq_o, hyper_dq_oe_o, hyper_rwds_o, hyper_rwds_oe_o
   );

   modport slave (
      input  hyper_cs_ni, hyper_dq_i, hyper_rwds_i,
      output hyper_dq_o, hyper_dq_oe_o, hyper_rwds_o, hyper_rwds_oe_o
   );
endinterface

// File: rtl/hyperbus_resp_model.sv
// HyperRAM-like HyperBus responder: 3-word CA, fixed initial latency, linear/wrapped bursts, cfg register 0.
// Optional out-of-range detection is enabled by defining HYPERBUS_RESP_OOR_ERR_EN.
module hyperbus_resp_model #(
   parameter int          ADDR_W     = 10,
   parameter int          LAT_CYC    = 6,
   parameter int          FIXED_2X   = 1,
   parameter int          WRAP_WORDS = 16,
   parameter logic [15:0] CFG0_RST   = 16'h8F1F
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 hyper_reset_ni,
   hyperbus_resp_model_if.slave bus,
   output logic [15:0]          cfg0_o,
   output logic                 oor_err_o
);
   localparam int                LAT_N     = LAT_CYC * ((FIXED_2X != 0) ? 2 : 1);
   localparam int                LAT_W     = $clog2(LAT_N + 1);
   localparam logic [ADDR_W-1:0] WRAP_MASK = ADDR_W'(WRAP_WORDS - 1);
   localparam logic [1:0]        CA_RWDS   = (FIXED_2X != 0) ? 2'b11 : 2'b00;

   typedef enum logic [2:0] {S_IDLE, S_CA, S_LAT, S_RD, S_WR, S_REGW, S_HOLD} state_t;

   state_t            r_state, w_state;
   logic [15:0]       r_mem [0:(2**ADDR_W)-1];
   logic [31:0]       r_ca_hi;
   logic              r_ca_cnt, r_read, r_is_reg, r_linear, r_oor;
   logic [ADDR_W-1:0] r_addr;
   logic [LAT_W-1:0]  r_lat;
   logic [15:0]       r_dq_o, r_cfg0;
   logic [1:0]        r_rwds_o;
   logic              r_dq_oe, r_rwds_oe, r_oor_err;

   logic              w_rst, w_cs_n, w_decode;
   logic [ADDR_W-1:0] w_start, w_cur_addr, w_next_addr;
   logic              w_start_oor, w_cur_lin, w_cur_reg, w_cur_oor;
   logic [15:0]       w_rd_word, w_dq_o;
   logic [1:0]        w_rwds_o;
   logic              w_dq_oe, w_rwds_oe, w_addr_adv, w_mem_we, w_cfg_we;

   assign w_rst    = rst_i | ~hyper_reset_ni;
   assign w_cs_n   = bus.hyper_cs_ni;
   assign w_decode = (r_state == S_CA) && r_ca_cnt && !w_cs_n;

   // r_ca_hi holds ca[47:16]; the cycle's dq_i supplies ca[15:0] while word 2 is on the bus.
`ifdef HYPERBUS_RESP_OOR_ERR_EN
   logic [31:0] w_full;
   assign w_full      = {r_ca_hi[28:0], bus.hyper_dq_i[2:0]};
   assign w_start     = w_full[ADDR_W-1:0];
   assign w_start_oor = (|(w_full >> ADDR_W)) && !r_ca_hi[30];
`else
   assign w_start     = ADDR_W'({r_ca_hi[28:0], bus.hyper_dq_i[2:0]});
   assign w_start_oor = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk_i) begin
      if (w_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state;
      end
   end

   // Next-state logic; a deasserted chip select always wins.
   always_comb begin
      w_state = r_state;
      if (w_cs_n) begin
         w_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: w_state = S_CA;
            S_CA: begin
               if (!r_ca_cnt) begin
                  w_state = S_CA;
               end else if (r_ca_hi[30] && !r_ca_hi[31]) begin
                  w_state = S_REGW;
               end else if (LAT_N == 1) begin
                  w_state = r_ca_hi[31] ? S_RD : S_WR;
               end else begin
                  w_state = S_LAT;
               end
            end
            S_LAT: begin
               if (r_lat == LAT_W'(1)) begin
                  w_state = r_read ? S_RD : S_WR;
               end else begin
                  w_state = S_LAT;
               end
            end
            S_RD:    w_state = S_RD;
            S_WR:    w_state = S_WR;
            S_REGW:  w_state = S_HOLD;
            S_HOLD:  w_state = S_HOLD;
            default: w_state = S_IDLE;
         endcase
      end
   end

   // Read data is fetched on the edge that precedes its beat, so bursts run without bubbles.
   always_comb begin
      w_cur_addr = (r_state == S_CA) ? w_start : r_addr;
      w_cur_lin  = (r_state == S_CA) ? r_ca_hi[29] : r_linear;
      w_cur_reg  = (r_state == S_CA) ? r_ca_hi[30] : r_is_reg;
      w_cur_oor  = (r_state == S_CA) ? w_start_oor : r_oor;
      if (w_cur_lin) begin
         w_next_addr = w_cur_addr + ADDR_W'(1);
      end else begin
         w_next_addr = (w_cur_addr & ~WRAP_MASK) | ((w_cur_addr + ADDR_W'(1)) & WRAP_MASK);
      end
      if (w_cur_reg) begin
         w_rd_word = r_cfg0;
      end else if (w_cur_oor) begin
         w_rd_word = 16'hDEAD;
      end else begin
         w_rd_word = r_mem[w_cur_addr];
      end
      w_dq_o    = 16'h0000;
      w_dq_oe   = 1'b0;
      w_rwds_o  = 2'b00;
      w_rwds_oe = 1'b0;
      case (w_state)
         S_CA: begin
            w_rwds_oe = 1'b1;
            w_rwds_o  = CA_RWDS;
         end
         S_RD: begin
            w_dq_o    = w_rd_word;
            w_dq_oe   = 1'b1;
            w_rwds_o  = 2'b10;
            w_rwds_oe = 1'b1;
         end
         default: begin
            w_dq_o = 16'h0000;
         end
      endcase
      w_addr_adv = (w_state == S_RD) || ((r_state == S_WR) && !w_cs_n);
      w_mem_we   = (r_state == S_WR) && !w_cs_n && !r_oor && !w_rst;
      w_cfg_we   = (r_state == S_REGW) && !w_cs_n;
   end

   // CA capture, burst address, latency counter, config register and registered pad outputs.
   always_ff @(posedge clk_i) begin
      if (w_rst) begin
         r_ca_hi   <= 32'h0;
         r_ca_cnt  <= 1'b0;
         r_read    <= 1'b0;
         r_is_reg  <= 1'b0;
         r_linear  <= 1'b0;
         r_oor     <= 1'b0;
         r_addr    <= '0;
         r_lat     <= '0;
         r_dq_o    <= 16'h0000;
         r_dq_oe   <= 1'b0;
         r_rwds_o  <= 2'b00;
         r_rwds_oe <= 1'b0;
         r_cfg0    <= CFG0_RST;
         r_oor_err <= 1'b0;
      end else begin
         r_dq_o    <= w_dq_o;
         r_dq_oe   <= w_dq_oe;
         r_rwds_o  <= w_rwds_o;
         r_rwds_oe <= w_rwds_oe;
         if (r_state == S_IDLE) begin
            r_ca_hi[31:16] <= bus.hyper_dq_i;
            r_ca_cnt       <= 1'b0;
         end
         if ((r_state == S_CA) && !r_ca_cnt) begin
            r_ca_hi[15:0] <= bus.hyper_dq_i;
            r_ca_cnt      <= 1'b1;
         end
         if (w_decode) begin
            r_read   <= r_ca_hi[31];
            r_is_reg <= r_ca_hi[30];
            r_linear <= r_ca_hi[29];
            r_oor    <= w_start_oor;
            r_addr   <= w_start;
            r_lat    <= LAT_W'(LAT_N - 1);
            if (w_start_oor) begin
               r_oor_err <= 1'b1;
            end
         end
         if (r_state == S_LAT) begin
            r_lat <= r_lat - LAT_W'(1);
         end
         if (w_addr_adv) begin
            r_addr <= w_next_addr;
         end
         if (w_cfg_we) begin
            r_cfg0 <= bus.hyper_dq_i;
         end
      end
   end

   // Byte-masked write port; a set RWDS bit protects its byte. Contents survive reset.
   always_ff @(posedge clk_i) begin
      if (w_mem_we) begin
         if (!bus.hyper_rwds_i[1]) begin
            r_mem[r_addr][15:8] <= bus.hyper_dq_i[15:8];
         end
         if (!bus.hyper_rwds_i[0]) begin
            r_mem[r_addr][7:0] <= bus.hyper_dq_i[7:0];
         end
      end
   end

   assign bus.hyper_dq_o      = r_dq_o;
   assign bus.hyper_dq_oe_o   = r_dq_oe;
   assign bus.hyper_rwds_o    = r_rwds_o;
   assign bus.hyper_rwds_oe_o = r_rwds_oe;
   assign cfg0_o              = r_cfg0;
   assign oor_err_o           = r_oor_err;
endmodule

// File: tb/tb_hyperbus_resp_model.sv
// Directed bench for hyperbus_resp_model: drives the controller side on falling edges and checks on falling edges.
module tb_hyperbus_resp_model;
   localparam int LAT_N = 12;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        hyper_reset_ni = 1'b1;
   logic [15:0] cfg0_o;
   logic        oor_err_o;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] wd [9];
   logic [15:0] rexp [8];

   hyperbus_resp_model_if bus_if ();

   hyperbus_resp_model #(
      .ADDR_W(10), .LAT_CYC(6), .FIXED_2X(1), .WRAP_WORDS(16), .CFG0_RST(16'h8F1F)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .hyper_reset_ni(hyper_reset_ni),
      .bus(bus_if.slave),
      .cfg0_o(cfg0_o),
      .oor_err_o(oor_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [47:0] make_ca(input bit rd, input bit rg, input bit lin, input logic [31:0] wa);
      logic [47:0] c;
      c        = 48'h0;
      c[47]    = rd;
      c[46]    = rg;
      c[45]    = lin;
      c[44:16] = wa[31:3];
      c[2:0]   = wa[2:0];
      return c;
   endfunction

   // Leaves the bench at the falling edge on which CA word 2 has just been driven.
   task automatic ca_send(input logic [47:0] ca);
      @(negedge clk_i);
      bus_if.hyper_cs_ni = 1'b0;
      bus_if.hyper_dq_i  = ca[47:32];
      @(negedge clk_i);
      check_eq("ca_rwds_oe", 32'(bus_if.hyper_rwds_oe_o), 32'h1);
      check_eq("ca_rwds", 32'(bus_if.hyper_rwds_o), 32'h3);
      bus_if.hyper_dq_i = ca[31:16];
      @(negedge clk_i);
      bus_if.hyper_dq_i = ca[15:0];
   endtask

   // Writes wd[0..n-1]; wd[n] is driven in the cycle chip select rises and must be dropped.
   task automatic hb_write(input logic [31:0] wa, input bit lin, input int n, input logic [1:0] m);
      ca_send(make_ca(1'b0, 1'b0, lin, wa));
      repeat (LAT_N - 1) @(negedge clk_i);
      for (int j = 0; j < n; j++) begin
         @(negedge clk_i);
         bus_if.hyper_dq_i   = wd[j];
         bus_if.hyper_rwds_i = m;
      end
      @(negedge clk_i);
      bus_if.hyper_cs_ni  = 1'b1;
      bus_if.hyper_dq_i   = wd[n];
      bus_if.hyper_rwds_i = m;
   endtask

   task automatic hb_read(input logic [31:0] wa, input bit rg, input bit lin, input int n);
      ca_send(make_ca(1'b1, rg, lin, wa));
      repeat (LAT_N - 1) @(negedge clk_i);
      check_eq("lat_quiet", 32'(bus_if.hyper_dq_oe_o), 32'h0);
      for (int j = 0; j < n; j++) begin
         @(negedge clk_i);
         check_eq("rd_data", 32'(bus_if.hyper_dq_o), 32'(rexp[j]));
         check_eq("rd_oe", {30'h0, bus_if.hyper_dq_oe_o, bus_if.hyper_rwds_oe_o}, 32'h3);
         check_eq("rd_rwds", 32'(bus_if.hyper_rwds_o), 32'h2);
         if (j == n - 1) begin
            bus_if.hyper_cs_ni = 1'b1;
         end
      end
      @(negedge clk_i);
      check_eq("rd_oe_drop", {30'h0, bus_if.hyper_dq_oe_o, bus_if.hyper_rwds_oe_o}, 32'h0);
   endtask

   initial begin
      bus_if.hyper_cs_ni  = 1'b1;
      bus_if.hyper_dq_i   = 16'h0000;
      bus_if.hyper_rwds_i = 2'b00;
      repeat (3) @(negedge clk_i);
      check_eq("rst_dq", 32'(bus_if.hyper_dq_o), 32'h0);
      check_eq("rst_oe", {30'h0, bus_if.hyper_dq_oe_o, bus_if.hyper_rwds_oe_o}, 32'h0);
      check_eq("rst_rwds", 32'(bus_if.hyper_rwds_o), 32'h0);
      check_eq("rst_cfg0", 32'(cfg0_o), 32'h8F1F);
      check_eq("rst_oor", 32'(oor_err_o), 32'h0);
      rst_i = 1'b0;

      // Linear write then read back with exact latency.
      wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333; wd[3] = 16'h9999;
      hb_write(32'h010, 1'b1, 3, 2'b00);
      rexp[0] = 16'h1111; rexp[1] = 16'h2222; rexp[2] = 16'h3333;
      hb_read(32'h010, 1'b0, 1'b1, 3);

      // Upper byte masked.
      wd[0] = 16'hABCD; wd[1] = 16'h0000;
      hb_write(32'h010, 1'b1, 1, 2'b10);
      rexp[0] = 16'h11CD;
      hb_read(32'h010, 1'b0, 1'b1, 1);

      // Wrapped read across the 16-word boundary.
      wd[0] = 16'hA00E; wd[1] = 16'hA00F; wd[2] = 16'h0000;
      hb_write(32'h00E, 1'b1, 2, 2'b00);
      wd[0] = 16'hA000; wd[1] = 16'hA001; wd[2] = 16'h0000;
      hb_write(32'h000, 1'b1, 2, 2'b00);
      rexp[0] = 16'hA00E; rexp[1] = 16'hA00F; rexp[2] = 16'hA000; rexp[3] = 16'hA001;
      hb_read(32'h00E, 1'b0, 1'b0, 4);

      // Zero-latency register write, trailing word ignored, then register read.
      ca_send(make_ca(1'b0, 1'b1, 1'b1, 32'h0));
      @(negedge clk_i);
      check_eq("cfg_pre", 32'(cfg0_o), 32'h8F1F);
      bus_if.hyper_dq_i = 16'h8F17;
      @(negedge clk_i);
      check_eq("cfg_wr", 32'(cfg0_o), 32'h8F17);
      bus_if.hyper_dq_i = 16'h1234;
      @(negedge clk_i);
      bus_if.hyper_cs_ni = 1'b1;
      @(negedge clk_i);
      check_eq("cfg_hold", 32'(cfg0_o), 32'h8F17);
      rexp[0] = 16'h8F17; rexp[1] = 16'h8F17;
      hb_read(32'h0, 1'b1, 1'b1, 2);

      // Bus reset restores the configuration register.
      @(negedge clk_i);
      hyper_reset_ni = 1'b0;
      @(negedge clk_i);
      check_eq("bus_rst_cfg0", 32'(cfg0_o), 32'h8F1F);
      hyper_reset_ni = 1'b1;

      // Abort during latency, then a write cut after two of four beats.
      wd[0] = 16'hEEE0; wd[1] = 16'hEEE1; wd[2] = 16'hEEE2; wd[3] = 16'hEEE3; wd[4] = 16'h0000;
      hb_write(32'h020, 1'b1, 4, 2'b00);
      ca_send(make_ca(1'b1, 1'b0, 1'b1, 32'h020));
      repeat (3) @(negedge clk_i);
      bus_if.hyper_cs_ni = 1'b1;
      repeat (LAT_N + 1) @(negedge clk_i);
      check_eq("lat_abort_oe", {30'h0, bus_if.hyper_dq_oe_o, bus_if.hyper_rwds_oe_o}, 32'h0);
      wd[0] = 16'h5551; wd[1] = 16'h5552; wd[2] = 16'h5553;
      hb_write(32'h020, 1'b1, 2, 2'b00);
      rexp[0] = 16'h5551; rexp[1] = 16'h5552; rexp[2] = 16'hEEE2; rexp[3] = 16'hEEE3;
      hb_read(32'h020, 1'b0, 1'b1, 4);

      // Start address 0x800 lies above the 10-bit array.
`ifdef HYPERBUS_RESP_OOR_ERR_EN
      rexp[0] = 16'hDEAD; rexp[1] = 16'hDEAD;
      hb_read(32'h800, 1'b0, 1'b1, 2);
      check_eq("oor_set", 32'(oor_err_o), 32'h1);
      repeat (2) @(negedge clk_i);
      check_eq("oor_sticky", 32'(oor_err_o), 32'h1);
`else
      rexp[0] = 16'hA000; rexp[1] = 16'hA001;
      hb_read(32'h800, 1'b0, 1'b1, 2);
      check_eq("oor_clear", 32'(oor_err_o), 32'h0);
`endif
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      check_eq("final_rst_oor", 32'(oor_err_o), 32'h0);
      check_eq("final_rst_cfg0", 32'(cfg0_o), 32'h8F1F);
      rst_i = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
